// File: rtl/spi_slave_reg_ctrl.sv
// SPI mode-0 slave frame sequencer: command byte, address byte, then an
// auto-incrementing burst of register writes or reads on the sclk domain.
module spi_slave_reg_ctrl #(
   parameter int         WIDTH  = 8,
   parameter logic [7:0] CMD_WR = 8'h02,
   parameter logic [7:0] CMD_RD = 8'h03
) (
   input  logic             sclk,
   input  logic             rst,
   input  logic             cs,
   input  logic             mosi,
   output logic             miso,
   output logic             miso_oe,
   output logic [WIDTH-1:0] reg_addr,
   output logic [WIDTH-1:0] reg_wdata,
   output logic             reg_we,
   input  logic [WIDTH-1:0] reg_rdata,
   output logic             cmd_err
);

   localparam int               CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [WIDTH-1:0] ADDR_ONE = WIDTH'(1);

   localparam logic [1:0] ST_CMD    = 2'd0;
   localparam logic [1:0] ST_ADDR   = 2'd1;
   localparam logic [1:0] ST_DATA   = 2'd2;
   localparam logic [1:0] ST_IGNORE = 2'd3;

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic             rd_mode;
   // Only the previous WIDTH-1 bits are kept; the final bit is taken live from mosi.
   logic [WIDTH-2:0] rx_sr;
   logic [WIDTH-1:0] tx_sr;
   logic [WIDTH-1:0] rx_byte;
   logic             byte_done;
   logic             rd_active;

   assign rx_byte   = {rx_sr, mosi};
   assign byte_done = !cs && (cnt == CNT_LAST);
   assign rd_active = (state == ST_DATA) && rd_mode && !cs;

   assign reg_wdata = rx_byte;
   assign reg_we    = byte_done && (state == ST_DATA) && !rd_mode && !rst;
   assign miso_oe   = rd_active;
   assign miso      = rd_active & tx_sr[WIDTH-1];

   // Frame control: a raised cs restarts decoding at the command byte.
   always_ff @(posedge sclk or posedge rst or posedge cs) begin
      if (rst || cs) begin
         state   <= ST_CMD;
         cnt     <= '0;
         rd_mode <= 1'b0;
      end else begin
         cnt <= byte_done ? '0 : cnt + CNT_ONE;
         if (byte_done) begin
            case (state)
               ST_CMD: begin
                  if (rx_byte == WIDTH'(CMD_WR)) begin
                     rd_mode <= 1'b0;
                     state   <= ST_ADDR;
                  end else if (rx_byte == WIDTH'(CMD_RD)) begin
                     rd_mode <= 1'b1;
                     state   <= ST_ADDR;
                  end else begin
                     state   <= ST_IGNORE;
                  end
               end
               ST_ADDR: state <= ST_DATA;
               default: state <= state;
            endcase
         end
      end
   end

   always_ff @(posedge sclk or posedge rst) begin
      if (rst) begin
         rx_sr <= '0;
      end else if (!cs) begin
         rx_sr <= rx_byte[WIDTH-2:0];
      end
   end

   // Address and error flag survive cs so they can be inspected between frames.
   always_ff @(posedge sclk or posedge rst) begin
      if (rst) begin
         reg_addr <= '0;
         cmd_err  <= 1'b0;
      end else if (byte_done) begin
         case (state)
            ST_CMD:  cmd_err  <= !((rx_byte == WIDTH'(CMD_WR)) || (rx_byte == WIDTH'(CMD_RD)));
            ST_ADDR: reg_addr <= rx_byte;
            ST_DATA: reg_addr <= reg_addr + ADDR_ONE;
            default: reg_addr <= reg_addr;
         endcase
      end
   end

   // Read data is fetched on the negedge that opens each byte, so the MSB is
   // on miso before the master's first sampling edge of that byte.
   always_ff @(negedge sclk or posedge rst or posedge cs) begin
      if (rst || cs) begin
         tx_sr <= '0;
      end else if ((state == ST_DATA) && rd_mode) begin
         if (cnt == '0) begin
            tx_sr <= reg_rdata;
         end else begin
            tx_sr <= {tx_sr[WIDTH-2:0], 1'b0};
         end
      end
   end

endmodule

// File: doc/spi_slave_reg_ctrl.md
Name: spi_slave_reg_ctrl

Overview:
SPI slave frame controller that turns the raw sclk-domain bit stream into register-bus transactions.
A frame is a command byte, an address byte, then one or more data bytes with burst auto-increment.
It generates write strobes and address/data for a register file clocked on sclk, and serialises read data onto miso.
It sits between the SPI pins and the sclk-domain register file. It is the sequencer for the shift-register receive datapath.

Parameters:
WIDTH, 8, bits per SPI word; also address and data width
CMD_WR, 8'h02, command code for write burst
CMD_RD, 8'h03, command code for read burst

Ports:
sclk  input  1  SPI clock; mode 0 only (sample on posedge, launch on negedge)
rst  input  1  asynchronous active-high reset
cs  input  1  chip select, active low
mosi  input  1  serial data in, MSB first
miso  output  1  serial data out, MSB first
miso_oe  output  1  high while read data is being driven
reg_addr  output  WIDTH  register address (registered)
reg_wdata  output  WIDTH  write data (combinational)
reg_we  output  1  write strobe, valid for the posedge it is high at (combinational)
reg_rdata  input  WIDTH  read data; must be valid within half an sclk period of a reg_addr change
cmd_err  output  1  sticky flag: last frame had an unknown command

Behaviour:
- Reset: rst=1 asynchronously clears state to CMD, cnt=0, rx_sr=0, tx_sr=0, reg_addr=0, miso=0, cmd_err=0. reg_we is forced to 0.
- Frame clear: cs=1 asynchronously clears state to CMD, cnt=0 and tx_sr=0. It does not clear reg_addr or cmd_err.
- Bit counter cnt (0..WIDTH-1): increments each posedge while cs=0 and wraps to 0 after WIDTH-1. A byte completes at the posedge where cnt==WIDTH-1. The completed byte is {rx_sr[WIDTH-2:0], mosi}.
- rx_sr shifts mosi in at every posedge while cs=0.
- CMD state, on byte completion:
  - byte==CMD_WR: set wr mode, go to ADDR, clear cmd_err.
  - byte==CMD_RD: set rd mode, go to ADDR, clear cmd_err.
  - any other byte: go to IGNORE, set cmd_err=1.
- ADDR state, on byte completion: reg_addr <= byte; go to DATA.
- DATA state, write mode, at the completing posedge:
  - reg_we=1 and reg_wdata=completed byte, both combinational for that posedge only, at the current reg_addr.
  - On the same edge reg_addr <= reg_addr+1, modulo 2^WIDTH (wraps from all-ones to 0).
  - reg_we is 0 at all other times and whenever cs=1 or rst=1.
- DATA state, read mode:
  - On the negedge where cnt==0, tx_sr <= reg_rdata.
  - On every other negedge in DATA, tx_sr <= tx_sr<<1.
  - On each completing posedge, reg_addr <= reg_addr+1 (wraps), so the next byte's data is fetched at the following negedge.
  - mosi content is ignored apart from counting.
- miso = tx_sr[WIDTH-1] when (state==DATA && rd mode && cs==0); otherwise 0.
- miso_oe is asserted under the same condition as miso.
- Latency: the first read bit is valid from the negedge after the address byte completes, i.e. before the master's first data-bit posedge. There is no dummy byte.
- IGNORE state: counts bits and issues no strobes until cs rises.
- Partial byte when cs rises: discarded. No write is issued, and reg_addr keeps its last value.
- rst mid-frame: everything clears immediately. The next frame starts at CMD after rst falls, with cs low or on the next cs fall.
- The frame state machine never leaves DATA except via cs or rst. Bursts are unbounded.

Test Plan:
- Write single: cs low, send 02,10,A5, cs high -> one reg_we pulse at the 24th posedge with reg_addr=10, reg_wdata=A5; reg_addr=11 afterwards; cmd_err=0.
- Write burst with wrap: send 02,FE,11,22,33 -> writes FE<=11, FF<=22, 00<=33; exactly 3 reg_we pulses.
- Read burst: model regs 20=3C, 21=C3; send 03,20 then 16 dummy bits -> miso carries 3C then C3 MSB first, each bit stable across its sampling posedge; miso_oe high only during those 16 bits; reg_we never asserted.
- Bad command: send 7F,10,55 -> cmd_err=1, no reg_we, miso=0 throughout. A following frame 02,00,01 -> cmd_err=0 and a write of 01 to 00.
- Aborted frame: send 02,40 then 5 bits of data, cs high -> no reg_we. Next frame starts decoding at CMD, and 02,41,99 writes 41<=99.
- Reset mid-frame: assert rst during the 3rd bit of a read data byte -> miso=0, miso_oe=0, reg_addr=0 immediately. After release, a fresh 02,05,AA frame writes 05<=AA.
